// File: rtl/des_ctrl_pkg.sv
// Shared definitions for the DES round sequencer: state encoding, key-rotate tables, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package des_ctrl_pkg;

  localparam int ROUND_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Per-round C/D rotate amounts, two bits per round, round 0 in bits [1:0].
  // Listed below from round 15 (left) down to round 0 (right).
  localparam logic [31:0] ENC_SHIFT_TBL = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Decryption rotates right and skips the rotate before round 0, because
  // C/D already hold the fully rotated key (total left shift is 28).
  localparam logic [31:0] DEC_SHIFT_TBL = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
  };

  function automatic logic [1:0] shift_lookup(input logic [ROUND_IDX_W-1:0] idx,
                                              input logic                   dec);
    logic [4:0] bit_pos;
    bit_pos = {idx, 1'b0};
    return dec ? DEC_SHIFT_TBL[bit_pos +: 2] : ENC_SHIFT_TBL[bit_pos +: 2];
  endfunction

endpackage

// File: rtl/des_key_shift_lut.sv
// Maps round index and direction to the C/D rotate amount for that round.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: round_idx (round number minus 1), decrypt (1 = decrypt schedule),
//        key_shift (rotate amount 0..2).
module des_key_shift_lut
  import des_ctrl_pkg::*;
(
  input  logic [ROUND_IDX_W-1:0] round_idx,
  input  logic                   decrypt,
  output logic [1:0]             key_shift
);

  always_comb begin
    key_shift = shift_lookup(round_idx, decrypt);
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES datapath: IP load, NUM_ROUNDS rounds, FP, result handshake.
// Latency: OUT_VALID rises 2 + NUM_ROUNDS*ROUND_CYCLES edges after the accept edge.
// Backpressure: result held in DONE until OUT_READY; START_READY only in IDLE; ABORT cancels.
// Ports: CLK/RESET (sync, active-high); START_VALID/START_READY accept a block; ABORT cancels;
//        IP_CS_BAR, TEXT_LOAD, KEY_LOAD drive the load cycle; ROUND_EN, ROUND_IDX, KEY_SHIFT,
//        KEY_SHIFT_DIR, LAST_ROUND steer each round; FP_CS_BAR, OUT_VALID/OUT_READY return the
//        result; BUSY is high outside IDLE.
// Build option DES_DECRYPT_EN: adds the DECRYPT input (sampled at accept) and the decrypt key
//        schedule; without it the block is encrypt-only and KEY_SHIFT_DIR is always 0.
// All strobe outputs are registered: they are decoded from the next state and captured on the
// same edge as the state, so they are glitch-free and line up with the state cycle by cycle.
module des_round_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS   = 16,
  parameter int ROUND_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START_VALID,
  output logic                   START_READY,
  input  logic                   ABORT,
`ifdef DES_DECRYPT_EN
  input  logic                   DECRYPT,
`endif
  output logic                   IP_CS_BAR,
  output logic                   TEXT_LOAD,
  output logic                   KEY_LOAD,
  output logic                   ROUND_EN,
  output logic [ROUND_IDX_W-1:0] ROUND_IDX,
  output logic [1:0]             KEY_SHIFT,
  output logic                   KEY_SHIFT_DIR,
  output logic                   LAST_ROUND,
  output logic                   FP_CS_BAR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   BUSY
);

  localparam int SUB_W = 3;
  localparam logic [ROUND_IDX_W-1:0] LAST_RND = ROUND_IDX_W'(NUM_ROUNDS - 1);
  localparam logic [SUB_W-1:0]       LAST_SUB = SUB_W'(ROUND_CYCLES - 1);

  state_t                   state_q, state_nxt;
  logic [ROUND_IDX_W-1:0]   round_q, round_nxt;
  logic [SUB_W-1:0]         sub_q, sub_nxt;
  logic                     accept;
  logic                     decrypt_q;

  // Next-cycle values of the registered outputs.
  logic                     start_ready_nxt;
  logic                     busy_nxt;
  logic                     ip_cs_bar_nxt;
  logic                     load_nxt;
  logic                     round_en_nxt;
  logic [ROUND_IDX_W-1:0]   round_idx_nxt;
  logic [1:0]               key_shift_nxt;
  logic [1:0]               lut_shift;
  logic                     key_dir_nxt;
  logic                     last_round_nxt;
  logic                     fp_cs_bar_nxt;
  logic                     out_valid_nxt;

  // START_READY is exactly "state is IDLE", so the accept can use the state directly.
  assign accept = (state_q == ST_IDLE) && START_VALID;

`ifdef DES_DECRYPT_EN
  // Direction is latched at accept and held for the whole block; the host may change
  // DECRYPT freely once the block is accepted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      decrypt_q <= 1'b0;
    end else if (accept) begin
      decrypt_q <= DECRYPT;
    end
  end
`else
  assign decrypt_q = 1'b0;
`endif

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state_q;
    round_nxt = round_q;
    sub_nxt   = sub_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_ROUND;
        round_nxt = '0;
        sub_nxt   = '0;
      end
      ST_ROUND: begin
        if (sub_q == LAST_SUB) begin
          sub_nxt = '0;
          if (round_q == LAST_RND) begin
            state_nxt = ST_FINAL;
            round_nxt = '0;
          end else begin
            round_nxt = round_q + 1'b1;
          end
        end else begin
          sub_nxt = sub_q + 1'b1;
        end
      end
      ST_FINAL: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        round_nxt = '0;
        sub_nxt   = '0;
      end
    endcase

    // Abort wins over every other transition, including the DONE handshake.
    if (ABORT && (state_q != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      round_nxt = '0;
      sub_nxt   = '0;
    end
  end

  // Rotate amount is looked up for the round about to be entered so it is
  // registered alongside ROUND_IDX and stays stable across multicycle rounds.
  des_key_shift_lut u_shift_lut (
    .round_idx (round_nxt),
    .decrypt   (decrypt_q),
    .key_shift (lut_shift)
  );

  // ------------------------------------------------------------- output decode
  always_comb begin
    start_ready_nxt = 1'b0;
    busy_nxt        = 1'b1;
    ip_cs_bar_nxt   = 1'b1;
    load_nxt        = 1'b0;
    round_en_nxt    = 1'b0;
    round_idx_nxt   = '0;
    key_shift_nxt   = '0;
    key_dir_nxt     = 1'b0;
    last_round_nxt  = 1'b0;
    fp_cs_bar_nxt   = 1'b1;
    out_valid_nxt   = 1'b0;

    case (state_nxt)
      ST_IDLE: begin
        start_ready_nxt = 1'b1;
        busy_nxt        = 1'b0;
      end
      ST_LOAD: begin
        ip_cs_bar_nxt = 1'b0;
        load_nxt      = 1'b1;
      end
      ST_ROUND: begin
        round_en_nxt   = (sub_nxt == LAST_SUB);
        round_idx_nxt  = round_nxt;
        key_shift_nxt  = lut_shift;
        key_dir_nxt    = decrypt_q;
        last_round_nxt = (round_nxt == LAST_RND);
      end
      ST_FINAL: begin
        fp_cs_bar_nxt = 1'b0;
      end
      ST_DONE: begin
        fp_cs_bar_nxt = 1'b0;
        out_valid_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b1;
      end
    endcase
  end

  // ----------------------------------------------------------------- registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      round_q       <= '0;
      sub_q         <= '0;
      START_READY   <= 1'b1;
      BUSY          <= 1'b0;
      IP_CS_BAR     <= 1'b1;
      TEXT_LOAD     <= 1'b0;
      KEY_LOAD      <= 1'b0;
      ROUND_EN      <= 1'b0;
      ROUND_IDX     <= '0;
      KEY_SHIFT     <= '0;
      KEY_SHIFT_DIR <= 1'b0;
      LAST_ROUND    <= 1'b0;
      FP_CS_BAR     <= 1'b1;
      OUT_VALID     <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      round_q       <= round_nxt;
      sub_q         <= sub_nxt;
      START_READY   <= start_ready_nxt;
      BUSY          <= busy_nxt;
      IP_CS_BAR     <= ip_cs_bar_nxt;
      TEXT_LOAD     <= load_nxt;
      KEY_LOAD      <= load_nxt;
      ROUND_EN      <= round_en_nxt;
      ROUND_IDX     <= round_idx_nxt;
      KEY_SHIFT     <= key_shift_nxt;
      KEY_SHIFT_DIR <= key_dir_nxt;
      LAST_ROUND    <= last_round_nxt;
      FP_CS_BAR     <= fp_cs_bar_nxt;
      OUT_VALID     <= out_valid_nxt;
    end
  end

endmodule
